// File: rtl/toupper_pkg.sv
// toupper_pkg: shared mode encoding and ASCII letter bounds for the case converter
package toupper_pkg;
  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_UPPER  = 2'd1,
    MODE_LOWER  = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_t;
  localparam logic [7:0] ASCII_UP_LO = 8'h41;
  localparam logic [7:0] ASCII_UP_HI = 8'h5A;
  localparam logic [7:0] ASCII_LO_LO = 8'h61;
  localparam logic [7:0] ASCII_LO_HI = 8'h7A;
  localparam int CASE_BIT = 5;
endpackage

// File: rtl/case_conv_lane.sv
// case_conv_lane: combinational single-byte case converter
// ports: din_i byte in, mode_i conversion mode, keep_i lane valid,
//        dout_o converted byte, changed_o high when dout_o differs from din_i
module case_conv_lane
  import toupper_pkg::*;
(
  input  logic [7:0] din_i,
  input  mode_t      mode_i,
  input  logic       keep_i,
  output logic [7:0] dout_o,
  output logic       changed_o
);
  logic is_up, is_lo, flip;
  always_comb begin
    is_up = din_i >= ASCII_UP_LO && din_i <= ASCII_UP_HI;
    is_lo = din_i >= ASCII_LO_LO && din_i <= ASCII_LO_HI;
    flip = keep_i & ((mode_i == MODE_UPPER  & is_lo) |
                     (mode_i == MODE_LOWER  & is_up) |
                     (mode_i == MODE_TOGGLE & (is_up | is_lo)));
    dout_o = din_i ^ (8'(flip) << CASE_BIT);
    changed_o = flip;
  end
endmodule

// File: rtl/toupper_stream.sv
// toupper_stream: registered multi-lane ASCII case converter with valid/ready and change counter
// ports: s_* input beat (data/keep/last, valid/ready), mode sampled on accept,
//        m_* registered output beat, cnt_clr clears conv_count (saturating changed-byte count)
module toupper_stream
  import toupper_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [8*LANES-1:0] s_data,
  input  logic [LANES-1:0]   s_keep,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [8*LANES-1:0] m_data,
  output logic [LANES-1:0]   m_keep,
  output logic               m_last,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   conv_count
);
  localparam int PC_W = $clog2(LANES + 1);
  logic               valid_q, last_q, accept;
  logic [8*LANES-1:0] data_q, data_d;
  logic [LANES-1:0]   keep_q, changed;
  logic [PC_W-1:0]    inc;
  logic [CNT_W:0]     sum;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    case_conv_lane u_lane (
      .din_i    (s_data[8*i+:8]),
      .mode_i   (mode_t'(mode)),
      .keep_i   (s_keep[i]),
      .dout_o   (data_d[8*i+:8]),
      .changed_o(changed[i])
    );
  end
  assign s_ready = !rst & (!valid_q | m_ready);
  assign accept  = s_valid & s_ready;
  always_comb begin
    inc = '0;
    for (int i = 0; i < LANES; i++) inc = inc + PC_W'(changed[i]);
    sum = {1'b0, cnt_q} + (CNT_W + 1)'(inc);
    cnt_d = cnt_clr ? '0 : !accept ? cnt_q : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        data_q  <= data_d;
        keep_q  <= s_keep;
        last_q  <= s_last;
      end else if (m_ready) begin
        valid_q <= 1'b0;
      end
      cnt_q <= cnt_d;
    end
  end
  assign m_valid    = valid_q;
  assign m_data     = data_q;
  assign m_keep     = keep_q;
  assign m_last     = last_q;
  assign conv_count = cnt_q;
endmodule
